instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Multi-cycle instruction fetch stage, directly downstream of the PC register.
//  - Takes the current PC and a fetch command from the control FSM.
//  - Runs a valid/ready read on instruction memory and latches the returned word into the IR.
//  - Produces PC+PC_INC as the sequential next-PC candidate for the PC write path.
//  - Handles flush (branch redirect), memory timeout and misaligned PC.
// PARAMETERS
//  ADDR_W   16  address/PC width
//  DATA_W   16  instruction word width
//  PC_INC   2   byte increment added to the fetched address
//  TIMEOUT  15  max cycles in REQ+WAIT before fault; 1..255
// PORTS
//  CLK                 in   1       clock; all state updates on rising edge
//  Reset               in   1       synchronous reset, active-high
//  input_PC            in   ADDR_W  current PC value
//  input_fetch_start   in   1       control requests one fetch (level, sampled in IDLE)
//  input_flush         in   1       abandon fetch in flight (branch redirect)
//  input_mem_ready     in   1       memory accepts request this cycle
//  input_mem_rvalid    in   1       read data valid this cycle
//  input_mem_rdata     in   DATA_W  read data
//  output_mem_req      out  1       request valid (registered)
//  output_mem_addr     out  ADDR_W  request address (registered)
//  output_IR           out  DATA_W  instruction register
//  output_PCplus       out  ADDR_W  fetched address + PC_INC, mod 2^ADDR_W
//  output_fetch_done   out  1       1-cycle pulse: IR/PCplus newly valid
//  output_busy         out  1       high in any state other than IDLE
//  output_fault        out  1       sticky: timeout or misaligned PC
// BEHAVIOUR
//  Reset
//   - State = IDLE; IR, PCplus, mem_addr = 0; req, done, fault = 0; timeout count = 0.
//   - Reset mid-fetch drops the request the next cycle.
//   - A late rvalid after reset is ignored.
//  States: IDLE, REQ, WAIT, DRAIN.
//  IDLE
//   - start=1, flush=0, fault=0, input_PC[0]=0: latch mem_addr=input_PC, go to REQ.
//   - start=1 with input_PC[0]=1: set fault, stay IDLE, no request issued.
//   - flush wins over start in the same cycle; no fetch is started.
//  REQ
//   - req=1; addr held stable until ready=1 is sampled.
//   - ready=1, rvalid=0: go to WAIT, deassert req.
//   - ready=1 and rvalid=1 in the same cycle: capture as in WAIT, then go to IDLE.
//  WAIT
//   - On rvalid: IR<=rdata, PCplus<=mem_addr+PC_INC (wraps FFFE->0000).
//   - done=1 for the following cycle; go to IDLE.
//  Flush
//   - In REQ before acceptance: drop req next cycle, go to IDLE.
//   - In WAIT, or in REQ with ready=1 that cycle: go to DRAIN.
//   - DRAIN waits for one rvalid, discards it, then goes to IDLE.
//   - DRAIN does not update IR, PCplus or done.
//  Timeout
//   - Counter clears on entry to REQ and increments each cycle in REQ/WAIT.
//   - Reaching TIMEOUT: fault=1, req=0, go to IDLE, IR unchanged.
//   - DRAIN also times out to IDLE but does not set fault.
//  Fault is sticky until Reset; while fault=1, start is ignored.
//  Latency: start sampled at edge 0, req visible cycle 1.
//   - ready in cycle 1, rvalid in cycle 2 gives done high in cycle 3.
//   - Minimum with ready+rvalid both in cycle 1: done high in cycle 2.
//  start held high through a fetch is re-sampled only on return to IDLE.
//  Exactly one outstanding memory read at any time.
// STRUCTURE
//  Shared include fetch_defs.vh: state encodings (2-bit), PC_INC default, TIMEOUT default.
//  Sub-module fetch_timeout_counter: 8-bit clear/enable/terminal-count; outputs expired.
//  FSM, IR and PCplus registers live in the top level.
// TESTING
//  T1 PC=0x0010, start; ready cyc1, rvalid cyc2 rdata=0xA5C3
//     -> done cyc3, IR=0xA5C3, PCplus=0x0012, busy=0 cyc3.
//  T2 PC=0xFFFE, ready+rvalid same cycle, rdata=0x1234
//     -> IR=0x1234, PCplus=0x0000, done one cycle later.
//  T3 PC=0x0020, ready held 0 for 20 cycles, TIMEOUT=15
//     -> fault=1 after 15 cycles, req=0, IR unchanged, later start ignored.
//  T4 PC=0x0040 accepted, flush in WAIT, rvalid 3 cycles later rdata=0xDEAD
//     -> IR unchanged, no done, IDLE after rvalid.
//  T5 start with PC=0x0031 -> fault=1 next cycle, mem_req never asserted.
//  T6 Reset asserted while in WAIT -> all outputs zero next cycle; later rvalid ignored.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// default geometry and timeout limits.
package instr_fetch_unit_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_PC_INC  = 2;
  localparam int DEF_TIMEOUT = 15;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  // The timeout window is TIMEOUT cycles, so the counter fires one below it.
  function automatic logic [CNT_W-1:0] terminal_count(input int timeout);
    return CNT_W'(timeout - 1);
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Saturating 8-bit cycle counter with clear/enable; flags when the count has
// reached the terminal value.
module fetch_timeout_counter
  import instr_fetch_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values, independent of process ordering in simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count >= terminal);

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch: valid/ready read of instruction memory into
// the IR, sequential next-PC candidate, flush, timeout and misalignment fault.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PC_INC  = DEF_PC_INC,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] input_PC,
  input  logic              input_fetch_start,
  input  logic              input_flush,
  input  logic              input_mem_ready,
  input  logic              input_mem_rvalid,
  input  logic [DATA_W-1:0] input_mem_rdata,
  output logic              output_mem_req,
  output logic [ADDR_W-1:0] output_mem_addr,
  output logic [DATA_W-1:0] output_IR,
  output logic [ADDR_W-1:0] output_PCplus,
  output logic              output_fetch_done,
  output logic              output_busy,
  output logic              output_fault
);

  fetch_state_t state, state_next;

  logic go;
  logic launch;
  logic misalign;
  logic capture;
  logic set_fault;
  logic cnt_clear;
  logic cnt_en;
  logic expired;

  assign go = input_fetch_start && !input_flush && !output_fault;

  fetch_timeout_counter u_timeout (
    .clk      (CLK),
    .reset    (Reset),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .terminal (terminal_count(TIMEOUT)),
    .expired  (expired)
  );

  always_ff @(posedge CLK) begin : fsm_state
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every variable assigned in a combinational block gets a default on
  // entry, so no path leaves it unassigned and no latch is inferred.
  always_comb begin : fsm_next
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (go && !input_PC[0]) state_next = ST_REQ;
      end
      ST_REQ: begin
        if (input_mem_ready && input_mem_rvalid) begin
          state_next = ST_IDLE;
        end else if (input_mem_ready) begin
          state_next = input_flush ? ST_DRAIN : ST_WAIT;
        end else if (input_flush || expired) begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (input_mem_rvalid) begin
          state_next = ST_IDLE;
        end else if (input_flush) begin
          state_next = ST_DRAIN;
        end else if (expired) begin
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (input_mem_rvalid || expired) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Entering DRAIN restarts the counter so the abandoned read gets a full window.
  always_comb begin : fsm_outputs
    launch    = 1'b0;
    misalign  = 1'b0;
    capture   = 1'b0;
    set_fault = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        launch    = go && !input_PC[0];
        misalign  = go && input_PC[0];
        cnt_clear = go && !input_PC[0];
      end
      ST_REQ: begin
        cnt_en    = 1'b1;
        capture   = input_mem_ready && input_mem_rvalid && !input_flush;
        set_fault = !input_mem_ready && !input_flush && expired;
        cnt_clear = input_mem_ready && !input_mem_rvalid && input_flush;
      end
      ST_WAIT: begin
        cnt_en    = 1'b1;
        capture   = input_mem_rvalid && !input_flush;
        set_fault = !input_mem_rvalid && !input_flush && expired;
        cnt_clear = !input_mem_rvalid && input_flush;
      end
      ST_DRAIN: begin
        cnt_en = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: there is no storage array here, so every register is cleared by
  // Reset; a late rvalid after Reset lands in IDLE and is ignored.
  always_ff @(posedge CLK) begin : datapath
    if (Reset) begin
      output_mem_req    <= 1'b0;
      output_mem_addr   <= '0;
      output_IR         <= '0;
      output_PCplus     <= '0;
      output_fetch_done <= 1'b0;
      output_fault      <= 1'b0;
    end else begin
      output_mem_req    <= (state_next == ST_REQ);
      output_fetch_done <= capture;
      if (launch) begin
        output_mem_addr <= input_PC;
      end
      if (capture) begin
        output_IR     <= input_mem_rdata;
        output_PCplus <= output_mem_addr + ADDR_W'(PC_INC);
      end
      if (misalign || set_fault) begin
        output_fault <= 1'b1;
      end
    end
  end

  assign output_busy = (state != ST_IDLE);

endmodule
